// File: rtl/sys_defs_pkg.sv
// Shared pipeline definitions: superscalar width, EX/MEM and CDB packet layouts.
`ifndef WAYS
`define WAYS 3
`endif

package sys_defs;
  localparam int XLEN         = 32;
  localparam int REG_IDX_W    = 5;
  localparam int ROB_IDX_W    = 5;
  localparam int SYS_WAYS     = `WAYS;
  localparam int CQ_DEPTH_DEF = 8;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      alu_result;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } EX_MEM_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]      value;
  } CDB_PACKET;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]      value;
  } CQ_ENTRY;
endpackage

// File: rtl/complete_queue_compact.sv
// Valid-way compaction: each way's slot offset is the number of valid ways below it.
module cq_compact #(
  parameter int WAYS  = 3,
  parameter int SUM_W = $clog2(WAYS + 1)
) (
  input  logic [WAYS-1:0]            valid_i,
  output logic [WAYS-1:0][SUM_W-1:0] offset_o,
  output logic [SUM_W-1:0]           n_in_o
);

  logic [SUM_W-1:0] run_sum;

  always_comb begin
    run_sum  = '0;
    offset_o = '0;
    for (int i = 0; i < WAYS; i++) begin
      offset_o[i] = run_sum;
      run_sum     = run_sum + SUM_W'(valid_i[i]);
    end
    n_in_o = run_sum;
  end

endmodule

// File: rtl/complete_queue.sv
// Completion queue between EX and the CDB: compacts up to WAYS results per cycle
// into a circular buffer and broadcasts up to WAYS per cycle in FIFO order.
module complete_queue
  import sys_defs::*;
#(
  parameter int WAYS     = SYS_WAYS,
  parameter int CQ_DEPTH = CQ_DEPTH_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  EX_MEM_PACKET [WAYS-1:0]           ex_packet_in,
  input  logic                              squash,
  input  logic                              cdb_stall,
  output CDB_PACKET    [WAYS-1:0]           cdb_packet_out,
  output logic                              ex_stall,
  output logic [$clog2(CQ_DEPTH+1)-1:0]     cq_count
);

  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = $clog2(CQ_DEPTH + 1);
  localparam int NIN_W = $clog2(WAYS + 1);

  CQ_ENTRY                    mem_q [CQ_DEPTH];
  logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d, free_slots, n_out;
  logic [WAYS-1:0]            in_valid;
  logic [WAYS-1:0][NIN_W-1:0] slot_off;
  logic [NIN_W-1:0]           n_in;
  logic                       enq_en, deq_en;

  always_comb begin
    in_valid = '0;
    for (int i = 0; i < WAYS; i++) in_valid[i] = ex_packet_in[i].valid;
  end

  cq_compact #(.WAYS(WAYS), .SUM_W(NIN_W)) u_compact (
    .valid_i  (in_valid),
    .offset_o (slot_off),
    .n_in_o   (n_in)
  );

  // Stall depends only on registered occupancy, so a full group always fits.
  assign free_slots = CNT_W'(CQ_DEPTH) - count_q;
  assign ex_stall   = free_slots < CNT_W'(WAYS);
  assign enq_en     = !ex_stall && !squash;
  assign deq_en     = !cdb_stall && !squash;
  assign n_out      = !deq_en ? '0 :
                      (count_q < CNT_W'(WAYS)) ? count_q : CNT_W'(WAYS);
  assign cq_count   = count_q;

  always_comb begin
    head_d  = head_q + PTR_W'(n_out);
    tail_d  = tail_q;
    count_d = count_q - n_out;
    if (enq_en) begin
      tail_d  = tail_q + PTR_W'(n_in);
      count_d = count_d + CNT_W'(n_in);
    end
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (in_valid[i]) begin
          mem_q[tail_q + PTR_W'(slot_off[i])] <= '{
            rob_idx:      ex_packet_in[i].rob_idx,
            dest_reg_idx: ex_packet_in[i].dest_reg_idx,
            value:        ex_packet_in[i].alu_result
          };
        end
      end
    end
  end

  // Storage is never reset, so invalid lanes are forced to all-zero.
  always_comb begin
    cdb_packet_out = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (deq_en && (CNT_W'(k) < count_q)) begin
        cdb_packet_out[k].valid        = 1'b1;
        cdb_packet_out[k].rob_idx      = mem_q[head_q + PTR_W'(k)].rob_idx;
        cdb_packet_out[k].dest_reg_idx = mem_q[head_q + PTR_W'(k)].dest_reg_idx;
        cdb_packet_out[k].value        = mem_q[head_q + PTR_W'(k)].value;
      end
    end
  end

endmodule
